rijndael_encrypt_arbiter: RTL and testbench



---
 rtl/rijndael_encrypt_arbiter.sv | 164 ++++++++++++++++
 tb/tb_rijndael_encrypt_arbiter.sv | 266 ++++++++++++++++++++++++++
 2 files changed

// File: rtl/rijndael_encrypt_arbiter.sv
// Shares one rijndael_encrypt core among NREQ requesters; tagged valid/ready response channel.
// Define RIJNDAEL_ARB_FIXED_PRIO_EN for fixed lowest-index priority instead of round-robin.
module rijndael_encrypt_arbiter #(
  parameter int unsigned NB   = 4,
  parameter int unsigned NK   = 4,
  parameter int unsigned NREQ = 2,
  localparam int unsigned StateSize = 32 * NB,
  localparam int unsigned KeySize   = 32 * NK,
  localparam int unsigned IDW       = (NREQ > 1) ? $clog2(NREQ) : 1
) (
  input  logic                      clk_i,
  input  logic                      rst_ni,
  input  logic [NREQ-1:0]           req_valid_i,
  output logic [NREQ-1:0]           req_ready_o,
  input  logic [NREQ*StateSize-1:0] req_plaintext_i,
  input  logic [NREQ*KeySize-1:0]   req_key_i,
  output logic                      resp_valid_o,
  input  logic                      resp_ready_i,
  output logic [StateSize-1:0]      resp_data_o,
  output logic [IDW-1:0]            resp_id_o,
  output logic                      busy_o,
  output logic                      core_enable_o,
  output logic [StateSize-1:0]      core_plaintext_o,
  output logic [KeySize-1:0]        core_key_o,
  input  logic                      core_ready_i,
  input  logic                      core_valid_i,
  input  logic [StateSize-1:0]      core_ciphertext_i
);

  typedef enum logic [2:0] {
    StIdle,
    StLaunch,
    StSpin,
    StWait,
    StResp
  } state_e;

  state_e                 state_q;
  logic [StateSize-1:0]   pt_q;
  logic [KeySize-1:0]     key_q;
  logic [StateSize-1:0]   result_q;
  logic [IDW-1:0]         id_q;
  logic                   busy_q;
  logic                   core_en_q;
  logic                   resp_valid_q;

  logic                   grant_vld;
  logic [IDW-1:0]         grant_idx;

`ifdef RIJNDAEL_ARB_FIXED_PRIO_EN
  // Scan from the top so the lowest valid index is the last to claim the grant.
  always_comb begin
    grant_vld = 1'b0;
    grant_idx = '0;
    for (int i = int'(NREQ) - 1; i >= 0; i--) begin
      if (req_valid_i[IDW'(i)]) begin
        grant_vld = 1'b1;
        grant_idx = IDW'(i);
      end
    end
  end
`else
  logic [IDW-1:0]         rr_ptr_q;
  int unsigned            cand;
  logic [IDW-1:0]         cand_idx;

  // Search starts one past the last winner and wraps, so the last winner is checked last.
  always_comb begin
    grant_vld = 1'b0;
    grant_idx = '0;
    cand      = 0;
    cand_idx  = '0;
    for (int unsigned i = 1; i <= NREQ; i++) begin
      cand     = (32'(rr_ptr_q) + i) % NREQ;
      cand_idx = IDW'(cand);
      if (!grant_vld && req_valid_i[cand_idx]) begin
        grant_vld = 1'b1;
        grant_idx = cand_idx;
      end
    end
  end

  always_ff @(posedge clk_i) begin
    if (!rst_ni) begin
      rr_ptr_q <= IDW'(NREQ - 1);
    end else if (state_q == StIdle && grant_vld) begin
      rr_ptr_q <= grant_idx;
    end
  end
`endif

  always_ff @(posedge clk_i) begin
    if (!rst_ni) begin
      state_q      <= StIdle;
      pt_q         <= '0;
      key_q        <= '0;
      result_q     <= '0;
      id_q         <= '0;
      busy_q       <= 1'b0;
      core_en_q    <= 1'b0;
      resp_valid_q <= 1'b0;
    end else begin
      unique case (state_q)
        StIdle: begin
          if (grant_vld) begin
            pt_q      <= req_plaintext_i[grant_idx*StateSize +: StateSize];
            key_q     <= req_key_i[grant_idx*KeySize +: KeySize];
            id_q      <= grant_idx;
            busy_q    <= 1'b1;
            core_en_q <= 1'b1;
            state_q   <= StLaunch;
          end
        end
        StLaunch: begin
          core_en_q <= 1'b0;
          state_q   <= StSpin;
        end
        StSpin: begin
          if (!core_ready_i) begin
            state_q <= StWait;
          end
        end
        StWait: begin
          // The core keeps its output only for this one valid cycle.
          if (core_valid_i) begin
            result_q     <= core_ciphertext_i;
            resp_valid_q <= 1'b1;
            state_q      <= StResp;
          end
        end
        StResp: begin
          if (resp_ready_i) begin
            resp_valid_q <= 1'b0;
            busy_q       <= 1'b0;
            state_q      <= StIdle;
          end
        end
        default: begin
          busy_q       <= 1'b0;
          core_en_q    <= 1'b0;
          resp_valid_q <= 1'b0;
          state_q      <= StIdle;
        end
      endcase
    end
  end

  // Gated by reset so nothing looks accepted while reset is asserted.
  always_comb begin
    req_ready_o = '0;
    if (rst_ni && state_q == StIdle && grant_vld) begin
      req_ready_o = NREQ'(1) << grant_idx;
    end
  end

  assign resp_valid_o     = resp_valid_q;
  assign resp_data_o      = result_q;
  assign resp_id_o        = id_q;
  assign busy_o           = busy_q;
  assign core_enable_o    = core_en_q;
  assign core_plaintext_o = pt_q;
  assign core_key_o       = key_q;

endmodule

// File: tb/tb_rijndael_encrypt_arbiter.sv
// Directed bench for rijndael_encrypt_arbiter with a behavioural stand-in for the encrypt core.
module tb_rijndael_encrypt_arbiter;

  localparam logic [127:0] FipsKey = 128'h000102030405060708090a0b0c0d0e0f;
  localparam logic [127:0] FipsPt  = 128'h00112233445566778899aabbccddeeff;
  localparam logic [127:0] FipsCt  = 128'h69c4e0d86a7b0430d8cdb78070b4c55a;
  localparam logic [127:0] PtB     = 128'hfedcba9876543210f0e1d2c3b4a59687;
  localparam logic [127:0] KeyB    = 128'h0f1e2d3c4b5a69788796a5b4c3d2e1f0;
  localparam logic [127:0] PtC     = 128'h13579bdf2468ace0deadbeefcafef00d;
  localparam logic [127:0] KeyC    = 128'hc001d00d0badf00d1234567889abcdef;

  logic         clk = 1'b0;
  logic         rst_n;
  logic [1:0]   req_valid;
  logic [1:0]   req_ready;
  logic [255:0] req_pt;
  logic [255:0] req_key;
  logic         resp_valid;
  logic         resp_ready;
  logic [127:0] resp_data;
  logic [0:0]   resp_id;
  logic         busy;
  logic         core_en;
  logic [127:0] core_pt;
  logic [127:0] core_key;
  logic         core_ready;
  logic         core_valid;
  logic [127:0] core_ct;

  int vectors     = 0;
  int miscompares = 0;

  always #5 clk = ~clk;

  rijndael_encrypt_arbiter #(.NB(4), .NK(4), .NREQ(2)) dut (
    .clk_i            (clk),
    .rst_ni           (rst_n),
    .req_valid_i      (req_valid),
    .req_ready_o      (req_ready),
    .req_plaintext_i  (req_pt),
    .req_key_i        (req_key),
    .resp_valid_o     (resp_valid),
    .resp_ready_i     (resp_ready),
    .resp_data_o      (resp_data),
    .resp_id_o        (resp_id),
    .busy_o           (busy),
    .core_enable_o    (core_en),
    .core_plaintext_o (core_pt),
    .core_key_o       (core_key),
    .core_ready_i     (core_ready),
    .core_valid_i     (core_valid),
    .core_ciphertext_i(core_ct)
  );

  // Known FIPS answer for the C.1 vector, an arbitrary keyed mix otherwise.
  function automatic logic [127:0] core_fn(input logic [127:0] p, input logic [127:0] k);
    if (p == FipsPt && k == FipsKey) return FipsCt;
    return p ^ {k[63:0], k[127:64]} ^ 128'h5a5a5a5a_a5a5a5a5_3c3c3c3c_c3c3c3c3;
  endfunction

  // Core model: ready drops after enable, valid for one cycle 12 cycles later, then output trashed.
  logic core_run, core_done;
  int   core_cnt;
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      core_run   <= 1'b0;
      core_ready <= 1'b1;
      core_valid <= 1'b0;
      core_done  <= 1'b0;
      core_cnt   <= 0;
      core_ct    <= '0;
    end else begin
      core_done <= 1'b0;
      if (core_valid) begin
        core_valid <= 1'b0;
        core_ready <= 1'b1;
        core_done  <= 1'b1;
      end else if (core_run) begin
        core_cnt <= core_cnt + 1;
        if (core_cnt == 10) begin
          core_valid <= 1'b1;
          core_run   <= 1'b0;
          core_ct    <= core_fn(core_pt, core_key);
        end
      end else if (core_en && core_ready) begin
        core_run   <= 1'b1;
        core_ready <= 1'b0;
        core_cnt   <= 0;
      end
      if (core_done) core_ct <= 128'hdeaddeaddeaddeaddeaddeaddeaddead;
    end
  end

  task automatic check(input string tag, input logic [127:0] obs, input logic [127:0] exp);
    vectors++;
    assert (obs === exp) else begin
      miscompares++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #2;
  endtask

  // One full transaction with resp_ready held high; optionally swaps the requester's plaintext mid-run.
  task automatic do_txn(input int id, input logic [127:0] exp_pt, input logic [127:0] exp_ct,
                        input logic drop, input logic swap, input logic [127:0] swap_pt);
    int n;
    int lat;
    logic [1:0] exp_gnt;
    exp_gnt = 2'b01 << id;
    #1;
    n = 0;
    while (req_ready === 2'b00 && n < 50) begin
      tick();
      #1;
      n++;
    end
    check("grant", {126'd0, req_ready}, {126'd0, exp_gnt});
    tick();
    lat = 1;
    if (drop) req_valid[id] = 1'b0;
    check("launch_enable", {127'd0, core_en}, 128'd1);
    check("launch_busy", {127'd0, busy}, 128'd1);
    while (!resp_valid && lat < 40) begin
      if (lat == 3 && swap) req_pt[id*128 +: 128] = swap_pt;
      if (lat == 5) check("core_pt_stable", core_pt, exp_pt);
      tick();
      lat++;
    end
    check("latency", 128'(lat), 128'd14);
    check("resp_data", resp_data, exp_ct);
    check("resp_id", {127'd0, resp_id}, 128'(id));
    tick();
    check("resp_drop", {127'd0, resp_valid}, 128'd0);
  endtask

  initial begin
    int n;
    logic seen;
    int exp_ids[4];

    // Reset state, with a request pending to prove req_ready stays low.
    rst_n      = 1'b0;
    req_valid  = 2'b01;
    resp_ready = 1'b1;
    req_pt     = {PtB, FipsPt};
    req_key    = {KeyB, FipsKey};
    tick();
    tick();
    #1;
    check("rst_req_ready", {126'd0, req_ready}, 128'd0);
    check("rst_busy", {127'd0, busy}, 128'd0);
    check("rst_resp_valid", {127'd0, resp_valid}, 128'd0);
    check("rst_core_en", {127'd0, core_en}, 128'd0);
    check("rst_resp_data", resp_data, 128'd0);
    check("rst_core_pt", core_pt, 128'd0);
    check("rst_core_key", core_key, 128'd0);
    req_valid = 2'b00;
    rst_n     = 1'b1;
    tick();

    // Single FIPS-197 request from requester 0.
    req_valid = 2'b01;
    do_txn(0, FipsPt, FipsCt, 1'b1, 1'b0, '0);
    check("idle_busy", {127'd0, busy}, 128'd0);

    // Response backpressure for 20 cycles with requester 1 waiting.
    resp_ready = 1'b0;
    req_pt[127:0]  = PtC;
    req_key[127:0] = KeyC;
    req_valid = 2'b01;
    #1;
    check("bp_grant", {126'd0, req_ready}, 128'd1);
    tick();
    req_valid = 2'b00;
    n = 0;
    while (!resp_valid && n < 40) begin
      tick();
      n++;
    end
    check("bp_resp_seen", {127'd0, resp_valid}, 128'd1);
    req_valid = 2'b10;
    #1;
    for (int i = 0; i < 20; i++) begin
      check("bp_valid", {127'd0, resp_valid}, 128'd1);
      check("bp_data", resp_data, core_fn(PtC, KeyC));
      check("bp_id", {127'd0, resp_id}, 128'd0);
      check("bp_req_ready", {126'd0, req_ready}, 128'd0);
      check("bp_core_en", {127'd0, core_en}, 128'd0);
      tick();
      #1;
    end
    req_valid  = 2'b00;
    resp_ready = 1'b1;
    tick();
    check("bp_release", {127'd0, resp_valid}, 128'd0);
    check("bp_idle", {127'd0, busy}, 128'd0);

    // Data isolation: plaintext changes after accept must not reach the core.
    req_pt[127:0]  = PtB;
    req_key[127:0] = KeyB;
    req_valid = 2'b01;
    do_txn(0, PtB, core_fn(PtB, KeyB), 1'b1, 1'b1, PtC);

    // Reset during WAIT drops the in-flight request.
    req_pt[127:0]  = FipsPt;
    req_key[127:0] = FipsKey;
    req_valid = 2'b01;
    #1;
    check("mid_grant", {126'd0, req_ready}, 128'd1);
    tick();
    req_valid = 2'b00;
    repeat (5) tick();
    rst_n = 1'b0;
    tick();
    rst_n = 1'b1;
    #1;
    check("mid_busy", {127'd0, busy}, 128'd0);
    check("mid_resp_valid", {127'd0, resp_valid}, 128'd0);
    check("mid_core_en", {127'd0, core_en}, 128'd0);
    check("mid_resp_data", resp_data, 128'd0);
    check("mid_core_pt", core_pt, 128'd0);
    check("mid_resp_id", {127'd0, resp_id}, 128'd0);
    seen = 1'b0;
    repeat (20) begin
      tick();
      if (resp_valid) seen = 1'b1;
    end
    check("mid_no_resp", {127'd0, seen}, 128'd0);
    req_valid = 2'b01;
    do_txn(0, FipsPt, FipsCt, 1'b1, 1'b0, '0);

    // Contention from a fresh reset, both requesters held valid.
    rst_n = 1'b0;
    tick();
    tick();
    rst_n = 1'b1;
    req_pt  = {PtB, FipsPt};
    req_key = {KeyB, FipsKey};
    req_valid = 2'b11;
`ifdef RIJNDAEL_ARB_FIXED_PRIO_EN
    exp_ids = '{0, 0, 0, 0};
`else
    exp_ids = '{0, 1, 0, 1};
`endif
    for (int i = 0; i < 4; i++) begin
      if (exp_ids[i] == 0) do_txn(0, FipsPt, FipsCt, 1'b0, 1'b0, '0);
      else                 do_txn(1, PtB, core_fn(PtB, KeyB), 1'b0, 1'b0, '0);
    end
    req_valid = 2'b00;
    tick();

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

  initial begin
    #500000;
    $display("FAIL watchdog: observed timeout expected completion");
    $fatal(1, "watchdog expired");
  end

endmodule
